// File: rtl/delay_line_prog.sv
// Programmable delay line: DEPTH shift stages with per-stage valid tags,
// a runtime-selected output tap, clock-enable stall and synchronous flush.
module delay_line_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int TAPW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [TAPW-1:0]  tap_sel,
  output logic [WIDTH-1:0] qout,
  output logic             qout_valid,
  output logic             busy
);

  localparam logic [TAPW-1:0] LAST_TAP = TAPW'(DEPTH - 1);

  logic [WIDTH-1:0] x [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [TAPW-1:0]  tap;

  // Out-of-range selections clamp to the last stage rather than wrapping.
  assign tap    = (tap_sel > LAST_TAP) ? LAST_TAP : tap_sel;
  assign v_next = {v[DEPTH-2:0], din_valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        x[i] <= '0;
      end
      v          <= '0;
      qout       <= '0;
      qout_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (flush) begin
      v          <= '0;
      qout_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (en) begin
      x[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        x[i] <= x[i-1];
      end
      v    <= v_next;
      busy <= |v_next;
      // The tap is read from pre-edge contents, so an invalid stage never reaches qout.
      if (v[tap]) begin
        qout       <= x[tap];
        qout_valid <= 1'b1;
      end else begin
        qout_valid <= 1'b0;
      end
    end else begin
      qout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_line_prog.sv
// Randomised bench for delay_line_prog: three depths share one stimulus
// and are each compared every edge against a history-based delay model.
module tb_delay_line_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, flush, din_valid;
  logic [7:0] din;
  logic [3:0] tap_sel;

  logic [7:0] q4, q16, q10;
  logic       qv4, qv16, qv10, b4, b16, b10;

  delay_line_prog #(.WIDTH(8), .DEPTH(4), .TAPW(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din_valid(din_valid),
    .din(din), .tap_sel(tap_sel), .qout(q4), .qout_valid(qv4), .busy(b4));
  delay_line_prog #(.WIDTH(8), .DEPTH(16), .TAPW(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din_valid(din_valid),
    .din(din), .tap_sel(tap_sel), .qout(q16), .qout_valid(qv16), .busy(b16));
  delay_line_prog #(.WIDTH(8), .DEPTH(10), .TAPW(4)) dut10 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din_valid(din_valid),
    .din(din), .tap_sel(tap_sel), .qout(q10), .qout_valid(qv10), .busy(b10));

  logic [7:0] qa [3];
  logic       qva [3];
  logic       ba [3];
  assign qa[0] = q4;   assign qa[1] = q16;  assign qa[2] = q10;
  assign qva[0] = qv4; assign qva[1] = qv16; assign qva[2] = qv10;
  assign ba[0] = b4;   assign ba[1] = b16;  assign ba[2] = b10;

  int checks = 0;
  int errors = 0;

  // Model: each instance remembers the {valid,data} accepted on its recent
  // enabled edges, newest first; entry t is what sits in stage t.
  int         depths [3] = '{4, 16, 10};
  logic [8:0] hist [3][$];
  logic [7:0] mq [3];
  logic       mv [3];
  logic       mb [3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hist[k].delete();
      mq[k] = 8'h00;
      mv[k] = 1'b0;
      mb[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int d;
      int t;
      d = depths[k];
      if (flush) begin
        for (int i = 0; i < hist[k].size(); i++) hist[k][i] = {1'b0, hist[k][i][7:0]};
        mv[k] = 1'b0;
        mb[k] = 1'b0;
      end else if (en) begin
        t = (int'(tap_sel) > d - 1) ? d - 1 : int'(tap_sel);
        if (hist[k].size() > t && hist[k][t][8]) begin
          mq[k] = hist[k][t][7:0];
          mv[k] = 1'b1;
        end else begin
          mv[k] = 1'b0;
        end
        hist[k].push_front({din_valid, din});
        while (hist[k].size() > d) void'(hist[k].pop_back());
        mb[k] = 1'b0;
        for (int i = 0; i < hist[k].size(); i++) mb[k] = mb[k] | hist[k][i][8];
      end else begin
        mv[k] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("qout_d%0d", depths[k]), 32'(qa[k]), 32'(mq[k]));
      checkOutput($sformatf("qout_valid_d%0d", depths[k]), 32'(qva[k]), 32'(mv[k]));
      checkOutput($sformatf("busy_d%0d", depths[k]), 32'(ba[k]), 32'(mb[k]));
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are compared 1 unit after the next.
  task automatic applyStimulus(input logic en_i, input logic fl_i, input logic dv_i,
                               input logic [7:0] d_i, input logic [3:0] tap_i);
    en = en_i; flush = fl_i; din_valid = dv_i; din = d_i; tap_sel = tap_i;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic latency(input int k, input logic [3:0] tap, input logic [7:0] d, input int exp_edges);
    int n;
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b1, d, tap);
    n = 1;
    while (!qva[k] && n < 40) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, tap);
      n++;
    end
    checkOutput($sformatf("latency_d%0d_tap%0d", depths[k], tap), 32'(n), 32'(exp_edges));
    checkOutput($sformatf("latency_data_d%0d", depths[k]), 32'(qa[k]), 32'(d));
  endtask

  logic [7:0] seq3 [3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int nvalid;
    logic [3:0] tap;
    rst = 1'b0; en = 1'b0; flush = 1'b0; din_valid = 1'b0; din = 8'h00; tap_sel = 4'd0;
    model_reset();
    #3;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Legacy 5-edge delay with three back-to-back samples.
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, 1'b0, e <= 3, (e <= 3) ? seq3[e-1] : 8'h00, 4'd3);
      if (e == 5) begin
        checkOutput("legacy_e5_q", 32'(q4), 32'h11);
        checkOutput("legacy_e5_v", 32'(qv4), 32'd1);
      end
      if (e == 6) checkOutput("legacy_e6_q", 32'(q4), 32'h22);
      if (e == 7) checkOutput("legacy_e7_q", 32'(q4), 32'h33);
      if (e == 7) checkOutput("legacy_e7_busy", 32'(b4), 32'd0);
      if (e == 8) checkOutput("legacy_e8_v", 32'(qv4), 32'd0);
    end

    latency(1, 4'd0, 8'hA5, 2);
    latency(1, 4'd15, 8'hA5, 17);
    latency(2, 4'd15, 8'hA5, 11);
    latency(0, 4'd9, 8'h3C, 5);

    // Stall mid-flight: five enabled edges, eight clocks.
    do_reset();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h5A, 4'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
    checkOutput("stall_early_v", 32'(qv4), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
    checkOutput("stall_out_v", 32'(qv4), 32'd1);
    checkOutput("stall_out_q", 32'(q4), 32'h5A);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
    checkOutput("stall_hold_v", 32'(qv4), 32'd0);
    checkOutput("stall_hold_q", 32'(q4), 32'h5A);

    // Bubbles: odd-index samples only.
    do_reset();
    for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 1'b0, i[0] & (i <= 8), 8'(i), 4'd3);
    checkOutput("bubble_last_q", 32'(q4), 32'h07);

    // Flush drops everything in flight, including the coincident sample.
    do_reset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'hC0 + 8'(i), 4'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE, 4'd3);
    checkOutput("flush_busy", 32'(b4), 32'd0);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
      nvalid += int'(qv4);
    end
    checkOutput("flush_no_valid", 32'(nvalid), 32'd0);
    latency(0, 4'd3, 8'h77, 5);

    // Async reset with the pipe full.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'h90 + 8'(i), 4'd3);
    do_reset();
    checkOutput("areset_busy", 32'(b4), 32'd0);
    checkOutput("areset_q", 32'(q4), 32'd0);

    // Random traffic including stalls, flushes, tap changes and resets.
    tap = 4'd3;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) tap = 4'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                    1'($urandom), 8'($urandom), tap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
